// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified memory port between the instruction-fetch stage
// (IF) and the load/store stage (D). Data requests win by default. A
// starvation counter forces a fetch grant after MAX_D_WINS consecutive data
// grants taken while IF was waiting. Once a requester is selected, the choice
// is locked until memory accepts it. The arbiter then tracks the single
// outstanding transaction and routes the response back to its owner.
//
// Optional feature (macro MEM_ARB_PERF_EN):
//   Adds free-running 32-bit stall counters if_stall_cnt / d_stall_cnt.
//   Each counter counts cycles in which its requester has req=1 and gnt=0.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   if_req/if_addr        fetch request in; if_gnt, if_rvalid, if_rdata out
//   d_req/d_we/d_addr/
//   d_wdata/d_be          data request in; d_gnt, d_rvalid, d_rdata out
//   mem_req/mem_we/
//   mem_addr/mem_wdata/
//   mem_be                memory request out
//   mem_gnt/mem_rvalid/
//   mem_rdata             memory handshake and response in
//   if_stall_cnt,
//   d_stall_cnt           (MEM_ARB_PERF_EN only) stall cycle counters
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MAX_D_WINS = 4,
    parameter int unsigned CW         = 3
) (
    input  logic            clk,
    input  logic            reset,
    // fetch requester
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    // data requester
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    // memory port
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]     if_stall_cnt,
    output logic [31:0]     d_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

    localparam logic [CW-1:0] MAX_W = CW'(MAX_D_WINS);

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            store_q, store_d;   // latched op of the D transaction
    logic [CW-1:0]   win_q,   win_d;     // consecutive D wins while IF waited

    logic            sel_d_idle;
    logic            cur_d;
    logic            req_active;
    logic            gnt_fire;
    logic            rsp_fire;

    // -------------------------------------------------------------------------
    // Selection and combinational request path
    // -------------------------------------------------------------------------
    always_comb begin
        // D wins unless IF is waiting and D has already used its quota.
        sel_d_idle = d_req && (!if_req || (win_q < MAX_W));

        // In IDLE the selection is live; afterwards it is frozen in owner_q.
        cur_d = (state_q == IDLE) ? sel_d_idle : (owner_q == OWN_D);

        // Gating with reset keeps every output at 0 while reset is asserted,
        // even though the IDLE request path is purely combinational.
        req_active = reset &&
                     ((state_q == IDLE)  ? (if_req || d_req) :
                      (state_q == ISSUE));

        gnt_fire = req_active && mem_gnt;

        // Responses are only accepted while a transaction is outstanding;
        // a stray mem_rvalid in IDLE or ISSUE is dropped.
        rsp_fire = reset && (state_q == WAIT_RESP) && mem_rvalid;
    end

    always_comb begin
        mem_req   = req_active;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (req_active) begin
            if (cur_d) begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_be    = d_be;
            end else begin
                mem_addr  = if_addr;
            end
        end

        if_gnt = gnt_fire && !cur_d;
        d_gnt  = gnt_fire &&  cur_d;

        if_rvalid = rsp_fire && (owner_q == OWN_IF);
        d_rvalid  = rsp_fire && (owner_q == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !store_q) ? mem_rdata : '0;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        store_d = store_q;
        win_d   = win_q;

        case (state_q)
            IDLE: begin
                if (req_active) begin
                    owner_d = cur_d ? OWN_D : OWN_IF;
                    store_d = cur_d && d_we;
                    state_d = mem_gnt ? WAIT_RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    // d_we is held stable until d_gnt, so relatching is safe.
                    store_d = (owner_q == OWN_D) && d_we;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (if_gnt) begin
            win_d = '0;
        end else if (d_gnt) begin
            if (if_req) begin
                if (win_q != '1) begin
                    win_d = win_q + 1'b1;
                end
            end else begin
                win_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            store_q <= 1'b0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            store_q <= store_d;
            win_q   <= win_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    // -------------------------------------------------------------------------
    // Stall counters (wrap at 2^32)
    // -------------------------------------------------------------------------
    logic [31:0] if_stall_q, if_stall_d;
    logic [31:0] d_stall_q,  d_stall_d;

    always_comb begin
        if_stall_d = if_stall_q;
        d_stall_d  = d_stall_q;
        if (if_req && !if_gnt) begin
            if_stall_d = if_stall_q + 32'd1;
        end
        if (d_req && !d_gnt) begin
            d_stall_d = d_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_stall_q <= '0;
            d_stall_q  <= '0;
        end else begin
            if_stall_q <= if_stall_d;
            d_stall_q  <= d_stall_d;
        end
    end

    assign if_stall_cnt = reset ? if_stall_q : '0;
    assign d_stall_cnt  = reset ? d_stall_q  : '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter. Inputs are driven on the falling
// clock edge. Outputs are sampled 1 time unit later, well away from the
// rising (active) edge. Build with MEM_ARB_PERF_EN to also check the stall
// counters.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;
    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]     if_stall_cnt;
    logic [31:0]     d_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .MAX_D_WINS (4),
        .CW         (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .if_stall_cnt (if_stall_cnt),
        .d_stall_cnt  (d_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Step to the next falling edge; stimulus is applied there.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_req     = 1'b0;
        if_addr    = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_be       = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        step();
        if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_addr = 32'h88;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if ({if_gnt, d_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {if_gnt, d_gnt}); end
        checks++; if ({if_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", {if_rvalid, d_rvalid}); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, d_rdata); end
        step();
        clear_inputs();
        reset = 1'b1;
        step();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_lone_fetch();
        if_req = 1'b1; if_addr = 32'h40; mem_gnt = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lone_mem_req: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin errors++; $display("FAIL lone_mem_fields: got addr %h we %b expected 40/0", mem_addr, mem_we); end
        checks++; if ({if_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL lone_gnt: got %b expected 10", {if_gnt, d_gnt}); end
        step();
        if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL lone_rsp: got %b/%h expected 1/00500093", if_rvalid, if_rdata); end
        checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin errors++; $display("FAIL lone_d_quiet: got %b/%h expected 0/0", d_rvalid, d_rdata); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lone_wait_mem_req: got %b expected 0", mem_req); end
        step();
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL lone_rvalid_pulse: got %b expected 0", if_rvalid); end
        step();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
        mem_gnt = 1'b1;
        #1;
        checks++; if ({if_gnt, d_gnt} !== 2'b01) begin errors++; $display("FAIL simul_gnt: got %b expected 01", {if_gnt, d_gnt}); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL simul_fields: got we %b addr %h expected 1/100", mem_we, mem_addr); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'hF) begin errors++; $display("FAIL simul_wdata: got %h/%h expected deadbeef/f", mem_wdata, mem_be); end
        step();
        d_req = 1'b0; d_we = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin errors++; $display("FAIL simul_store_ack: got %b/%h expected 1/0", d_rvalid, d_rdata); end
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL simul_if_quiet: got %b/%h expected 0/0", if_rvalid, if_rdata); end
        step();
        mem_rvalid = 1'b0; mem_gnt = 1'b1;
        #1;
        checks++; if ({if_gnt, d_gnt} !== 2'b10 || mem_addr !== 32'h80) begin errors++; $display("FAIL simul_if_next: got gnt %b addr %h expected 10/80", {if_gnt, d_gnt}, mem_addr); end
        step();
        if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL simul_if_rsp: got %b/%h expected 1/cafe0001", if_rvalid, if_rdata); end
        step();
        clear_inputs();
        step();
    endtask

    // -------------------------------------------------------------------------
    // IF waits the whole time; D (loads) keeps requesting. Expected owner
    // sequence: four D wins, forced IF win, then D again (counter cleared).
    task automatic test_starvation();
        logic [5:0] exp_d;
        int         d_wins_before_if;
        exp_d = 6'b10_1111;   // bit i = 1 means D owns transaction i
        d_wins_before_if = 0;
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int i = 0; i < 6; i++) begin
            mem_gnt = 1'b1; mem_rvalid = 1'b0;
            #1;
            if (exp_d[i]) begin
                checks++; if ({if_gnt, d_gnt} !== 2'b01 || mem_addr !== 32'h300) begin errors++; $display("FAIL starve_gnt_%0d: got gnt %b addr %h expected 01/300", i, {if_gnt, d_gnt}, mem_addr); end
            end else begin
                checks++; if ({if_gnt, d_gnt} !== 2'b10 || mem_addr !== 32'h200) begin errors++; $display("FAIL starve_gnt_%0d: got gnt %b addr %h expected 10/200", i, {if_gnt, d_gnt}, mem_addr); end
            end
            if (d_gnt && i < 5 && !if_gnt) d_wins_before_if++;
            if (if_gnt) begin
                checks++; if (d_wins_before_if !== 4) begin errors++; $display("FAIL starve_d_wins: got %0d expected 4", d_wins_before_if); end
            end
            step();
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA0 + i;
            #1;
            if (exp_d[i]) begin
                checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA0 + i || if_rvalid !== 1'b0) begin errors++; $display("FAIL starve_rsp_%0d: got d %b/%h if %b expected d 1/%h if 0", i, d_rvalid, d_rdata, if_rvalid, 32'hA0 + i); end
            end else begin
                checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA0 + i || d_rvalid !== 1'b0) begin errors++; $display("FAIL starve_rsp_%0d: got if %b/%h d %b expected if 1/%h d 0", i, if_rvalid, if_rdata, d_rvalid, 32'hA0 + i); end
            end
            step();
        end
        clear_inputs();
        step();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_mid_reset();
        if_req = 1'b1; if_addr = 32'h500; mem_gnt = 1'b1;
        #1;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt: got %b expected 1", if_gnt); end
        step();
        if_req = 1'b0; mem_gnt = 1'b0;
        step();
        // Now in WAIT_RESP: assert reset with busy inputs and a response.
        reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_addr = 32'h600;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL midrst_mem: got %b/%h expected 0/0", mem_req, mem_addr); end
        checks++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== 4'b0000) begin errors++; $display("FAIL midrst_ctrl: got %b expected 0000", {if_gnt, d_gnt, if_rvalid, d_rvalid}); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h/%h expected 0/0", if_rdata, d_rdata); end
        step();
        clear_inputs();
        reset = 1'b1;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        #1;
        checks++; if ({if_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL midrst_stray: got %b expected 00", {if_rvalid, d_rvalid}); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL midrst_stray_data: got %h/%h expected 0/0", if_rdata, d_rdata); end
        step();
        mem_rvalid = 1'b0; mem_rdata = '0;
        step();
    endtask

    // -------------------------------------------------------------------------
    // IF selected, memory stalls 3 cycles, d_req rises one cycle in.
    task automatic test_backpressure();
        if_req = 1'b1; if_addr = 32'h700; mem_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h700) begin errors++; $display("FAIL bp_hold_%0d: got %b/%h expected 1/700", c, mem_req, mem_addr); end
            checks++; if ({if_gnt, d_gnt} !== 2'b00) begin errors++; $display("FAIL bp_nognt_%0d: got %b expected 00", c, {if_gnt, d_gnt}); end
            step();
            if (c == 0) begin
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
            end
        end
        mem_gnt = 1'b1;
        #1;
        checks++; if ({if_gnt, d_gnt} !== 2'b10 || mem_addr !== 32'h700) begin errors++; $display("FAIL bp_if_gnt: got gnt %b addr %h expected 10/700", {if_gnt, d_gnt}, mem_addr); end
        step();
        if_req = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL bp_wait: got req %b d_gnt %b expected 0/0", mem_req, d_gnt); end
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1111_2222 || d_gnt !== 1'b0) begin errors++; $display("FAIL bp_if_rsp: got %b/%h d_gnt %b expected 1/11112222/0", if_rvalid, if_rdata, d_gnt); end
        step();
        mem_rvalid = 1'b0;
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_addr !== 32'h800) begin errors++; $display("FAIL bp_d_gnt: got %b/%h expected 1/800", d_gnt, mem_addr); end
        step();
        d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h3333_4444) begin errors++; $display("FAIL bp_d_rsp: got %b/%h expected 1/33334444", d_rvalid, d_rdata); end
        step();
        clear_inputs();
`ifdef MEM_ARB_PERF_EN
        // IF waited in cycles 0..2; D waited in cycles 1..5.
        #1;
        checks++; if (if_stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_if_stall: got %0d expected 3", if_stall_cnt); end
        checks++; if (d_stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_d_stall: got %0d expected 5", d_stall_cnt); end
`endif
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_starvation();
        test_mid_reset();
        test_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the `system` core between two requesters: the instruction-fetch stage (IF) and the load/store stage (D).
- Arbitrates between them, locks the chosen request until memory accepts it, then tracks the single outstanding transaction.
- Routes the response back to the requester that owns the transaction.
- Data requests win by default; a starvation counter forces a fetch grant after a configured number of consecutive data wins.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- MAX_D_WINS, 4, consecutive data grants allowed while IF is waiting before IF is forced to win; minimum 1.
- CW, 3, width of the starvation counter; must satisfy 2^CW > MAX_D_WINS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  1  fetch request; held stable until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch request accepted by memory this cycle.
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  DW  fetch read data.
- d_req  in  1  data request; held stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_be  in  DW/8  store byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response valid; also the store acknowledge.
- d_rdata  out  DW  load data; 0 for stores.
- mem_req  out  1  request to memory.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/AW/DW/DW/8  request fields.
- mem_gnt  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  memory response; exactly one per accepted request, at least 1 cycle after mem_gnt.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset state:
  - state = IDLE, owner = IF, d_win_cnt = 0.
  - All outputs are 0 while reset is low, regardless of the request inputs.
- States: IDLE, ISSUE, WAIT_RESP.
- Selection (IDLE only):
  - Only d_req: select D.
  - Only if_req: select IF.
  - Both: select IF if d_win_cnt >= MAX_D_WINS, else select D.
- IDLE:
  - mem_req = if_req | d_req; request fields are taken combinationally from the selected requester.
  - mem_gnt=1: pulse the selected gnt in the same cycle, latch owner, go to WAIT_RESP.
  - mem_gnt=0 with a request present: latch owner, go to ISSUE.
- ISSUE:
  - mem_req=1 with the latched owner's fields; the selection is frozen and a new d_req does not preempt.
  - On mem_gnt: owner gnt = 1, go to WAIT_RESP.
- WAIT_RESP:
  - mem_req=0 and no gnt is issued.
  - On mem_rvalid: pulse the owner's rvalid for 1 cycle; rdata = mem_rdata (d_rdata = 0 if the latched op was a store).
  - Go to IDLE next cycle; the next request can be granted at the earliest in the cycle after rvalid.
- Unowned side: rvalid = 0 and rdata = 0 at all times.
- d_win_cnt:
  - Increments (saturating at 2^CW-1) on each d_gnt while if_req is high.
  - Clears on if_gnt.
  - Clears on any d_gnt when if_req is low.
- Stray mem_rvalid in IDLE or ISSUE: ignored; no rvalid is issued.
- Minimum transaction time: 2 cycles (grant cycle plus a response one cycle later).
- Reset asserted mid-transaction: state returns to IDLE immediately; any late mem_rvalid after release is ignored as stray.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs if_stall_cnt [31:0] and d_stall_cnt [31:0].
  - Each counts cycles in which that requester's req=1 and its gnt=0.
  - Both are cleared by reset and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x40, mem_gnt=1 immediately, mem_rvalid 1 cycle later with rdata=0x00500093 -> if_gnt in cycle 0; if_rvalid=1 and if_rdata=0x00500093 in cycle 1; d_rvalid stays 0.
- Simultaneous requests with an empty counter: if_req=d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0xF -> D granted first, mem_we=1, mem_addr=0x100; d_rvalid with d_rdata=0; IF granted on the next IDLE.
- Starvation: if_req held high, d_req high for 6 back-to-back transactions, MAX_D_WINS=4 -> exactly 4 d_gnt, then if_gnt; d_win_cnt reads 0 after the if_gnt.
- Memory backpressure: mem_gnt held 0 for 3 cycles with IF selected, d_req rising in cycle 1 -> mem_addr stays at the IF address; if_gnt fires on the 4th cycle; no d_gnt until the IF response returns.
- Reset mid-transaction: reset pulled low in WAIT_RESP -> all outputs 0 immediately; a mem_rvalid pulse after reset release produces no if_rvalid or d_rvalid.
- MEM_ARB_PERF_EN defined, backpressure scenario -> if_stall_cnt = 3 and d_stall_cnt equals the number of cycles d_req was waiting.
